// File: rtl/bomb_manager_if.sv
// Board-side bundle for bomb_manager: game inputs toward the manager and
// the two 256-bit occupancy maps coming back. The master side is the game
// logic/bench, the slave side is the bomb manager itself.
interface bomb_manager_if;
  logic         tick;
  logic         game_active;
  logic [255:0] i_wall;
  logic [7:0]   p1_cor;
  logic [7:0]   p2_cor;
  logic         p1_place;
  logic         p2_place;
  logic [255:0] o_bomb;
  logic [255:0] o_explode;

  modport master (
    output tick, game_active, i_wall, p1_cor, p2_cor, p1_place, p2_place,
    input  o_bomb, o_explode
  );

  modport slave (
    input  tick, game_active, i_wall, p1_cor, p2_cor, p1_place, p2_place,
    output o_bomb, o_explode
  );
endinterface

// File: rtl/bomb_manager.sv
// Bomb manager: owns every live bomb slot on the 16x16 board, runs the
// fuse -> blast lifecycle per slot, resolves chain reactions and produces
// registered bomb and explosion maps (bit index = {row, col}).
module bomb_manager #(
  parameter int BOMBS_PER_PLAYER = 2,
  parameter int FUSE_TICKS       = 120,
  parameter int BLAST_TICKS      = 30,
  parameter int RANGE            = 2
) (
  input  logic          clk,
  input  logic          reset,
  bomb_manager_if.slave bus
);

  localparam int NSLOT = 2 * BOMBS_PER_PLAYER;
  localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE  = 2'd1,
    S_BLAST = 2'd2
  } slot_state_e;

  slot_state_e  state_q [NSLOT];
  slot_state_e  state_d [NSLOT];
  logic [7:0]   cor_q   [NSLOT];
  logic [7:0]   cor_d   [NSLOT];
  logic [7:0]   ctr_q   [NSLOT];
  logic [7:0]   ctr_d   [NSLOT];
  logic [255:0] bomb_q, bomb_d;
  logic [255:0] explode_q, explode_d;

  logic          p1_free, p2_free;
  logic          p1_occ, p2_occ;
  logic          p1_acc, p2_acc;
  logic [SW-1:0] p1_idx, p2_idx;

  assign bus.o_bomb    = bomb_q;
  assign bus.o_explode = explode_q;

  // Cross-shaped blast footprint around cell c: centre plus up to RANGE
  // cells per direction, stopping before a wall or at the board edge.
  function automatic logic [255:0] blast_map(input logic [7:0] c,
                                             input logic [255:0] wall);
    logic [255:0] m;
    logic [7:0]   idx;
    logic         go;
    int           row, col, r, cc;
    m   = '0;
    row = int'(c[7:4]);
    col = int'(c[3:0]);
    m[c] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      go = 1'b1;
      for (int k = 1; k <= 15; k++) begin
        r  = row;
        cc = col;
        case (d)
          0:       r  = row - k;
          1:       r  = row + k;
          2:       cc = col - k;
          default: cc = col + k;
        endcase
        if (go && (k <= RANGE)) begin
          if ((r < 0) || (r > 15) || (cc < 0) || (cc > 15)) begin
            go = 1'b0;
          end else begin
            idx = 8'(r * 16 + cc);
            if (wall[idx]) go = 1'b0;
            else           m[idx] = 1'b1;
          end
        end
      end
    end
    return m;
  endfunction

  // Placement arbitration and per-slot next state; chain detonation beats tick.
  always_comb begin
    p1_free = 1'b0;
    p2_free = 1'b0;
    p1_idx  = '0;
    p2_idx  = '0;
    p1_occ  = 1'b0;
    p2_occ  = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      state_d[i] = state_q[i];
      cor_d[i]   = cor_q[i];
      ctr_d[i]   = ctr_q[i];
    end

    for (int i = 0; i < BOMBS_PER_PLAYER; i++) begin
      if (!p1_free && (state_q[i] == S_IDLE)) begin
        p1_free = 1'b1;
        p1_idx  = SW'(i);
      end
    end
    for (int i = BOMBS_PER_PLAYER; i < NSLOT; i++) begin
      if (!p2_free && (state_q[i] == S_IDLE)) begin
        p2_free = 1'b1;
        p2_idx  = SW'(i);
      end
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (state_q[i] != S_IDLE) begin
        if (cor_q[i] == bus.p1_cor) p1_occ = 1'b1;
        if (cor_q[i] == bus.p2_cor) p2_occ = 1'b1;
      end
    end

    p1_acc = bus.game_active && bus.p1_place && p1_free &&
             !bus.i_wall[bus.p1_cor] && !p1_occ;
    // P1 wins a same-cell tie; the P2 request is simply dropped.
    p2_acc = bus.game_active && bus.p2_place && p2_free &&
             !bus.i_wall[bus.p2_cor] && !p2_occ &&
             !(p1_acc && (bus.p1_cor == bus.p2_cor));

    for (int i = 0; i < NSLOT; i++) begin
      case (state_q[i])
        S_FUSE: begin
          if (explode_q[cor_q[i]]) begin
            state_d[i] = S_BLAST;
            ctr_d[i]   = 8'(BLAST_TICKS);
          end else if (bus.tick) begin
            if (ctr_q[i] > 8'd1) begin
              ctr_d[i] = ctr_q[i] - 8'd1;
            end else begin
              state_d[i] = S_BLAST;
              ctr_d[i]   = 8'(BLAST_TICKS);
            end
          end
        end
        S_BLAST: begin
          if (bus.tick) begin
            if (ctr_q[i] > 8'd1) begin
              ctr_d[i] = ctr_q[i] - 8'd1;
            end else begin
              state_d[i] = S_IDLE;
              ctr_d[i]   = 8'd0;
            end
          end
        end
        default: ;
      endcase
    end

    if (p1_acc) begin
      state_d[p1_idx] = S_FUSE;
      cor_d[p1_idx]   = bus.p1_cor;
      ctr_d[p1_idx]   = 8'(FUSE_TICKS);
    end
    if (p2_acc) begin
      state_d[p2_idx] = S_FUSE;
      cor_d[p2_idx]   = bus.p2_cor;
      ctr_d[p2_idx]   = 8'(FUSE_TICKS);
    end
  end

  // Output maps are built from the current slot state and registered, so
  // they trail the slot state by one clock.
  always_comb begin
    bomb_d    = '0;
    explode_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (state_q[i] == S_FUSE)  bomb_d[cor_q[i]] = 1'b1;
      if (state_q[i] == S_BLAST) explode_d = explode_d | blast_map(cor_q[i], bus.i_wall);
    end
  end

  // Slot and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= S_IDLE;
        cor_q[i]   <= 8'd0;
        ctr_q[i]   <= 8'd0;
      end
      bomb_q    <= '0;
      explode_q <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= state_d[i];
        cor_q[i]   <= cor_d[i];
        ctr_q[i]   <= ctr_d[i];
      end
      bomb_q    <= bomb_d;
      explode_q <= explode_d;
    end
  end

endmodule

// File: doc/bomb_manager.md
# bomb_manager

Upstream of the game-over tracker: owns every live bomb on the 16x16 board and produces the 256-bit explosion map that the tracker samples at each player's coordinate. Accepts bomb-placement requests from both players and runs a fuse, then blast, state machine per bomb slot. Also computes cross-shaped blast patterns clipped by walls and board edges, and triggers chain reactions.

## Interface
- BOMBS_PER_PLAYER, 2, slots per player; P1 owns slots 0..BOMBS_PER_PLAYER-1, P2 owns the rest.
- FUSE_TICKS, 120, ticks from placement to blast; range 1..255.
- BLAST_TICKS, 30, ticks a blast stays lit; range 1..255.
- RANGE, 2, blast reach in cells per direction; range 1..15.

Ports (clock and reset first):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset: sampled on the rising edge of clk; reset==0 resets the block.
- tick  in  1  one-clk game-tick strobe (frame rate); all fuse and blast timing counts ticks.
- game_active  in  1  1 while a round is in play; placement is allowed only when high.
- i_wall  in  256  indestructible wall map; bit index is the cell coordinate.
- p1_cor, p2_cor  in  8  player cell as {row[7:4], col[3:0]}.
- p1_place, p2_place  in  1  placement request, sampled every clk (level, not edge).
- o_bomb  out  256  1 where a bomb is fusing.
- o_explode  out  256  1 where a blast is lit; this output feeds the game-over tracker.

## Operation
- Each slot holds {state, cor[7:0], ctr[7:0]}; states are IDLE, FUSE and BLAST.
- Reset (reset==0): all slots go to IDLE with cor=0 and ctr=0; o_bomb=0 and o_explode=0.
- Placement for player p is accepted when all of the following hold:
  - game_active=1 and p_place=1;
  - the player has an IDLE slot;
  - i_wall[p_cor]=0;
  - no non-IDLE slot (FUSE or BLAST) holds p_cor.
- On acceptance:
  - the lowest-index IDLE slot of that player goes to FUSE with cor=p_cor and ctr=FUSE_TICKS;
  - a held request re-attempts every clk but is rejected by the occupied-cell rule.
- Same-cycle requests on the same cell: P1 is accepted and P2 is dropped. Different cells are both accepted.
- FUSE:
  - on tick with ctr>1: ctr decrements;
  - on tick with ctr==1: go to BLAST with ctr=BLAST_TICKS.
- Chain reaction: a FUSE slot whose cell has o_explode[cor]=1 goes to BLAST with ctr=BLAST_TICKS on the next clk, regardless of tick. Chain detonation has priority over the tick decrement.
- BLAST:
  - on tick with ctr>1: ctr decrements;
  - on tick with ctr==1: go to IDLE, and the slot is reusable the same cycle it returns.
- Blast pattern for one slot:
  - the centre cell is lit;
  - in each of the four directions, cells at distance 1..RANGE are lit;
  - a direction stops at the first wall cell (the wall is not lit) or at the board edge. There is no wrap across rows or columns.
- o_explode is the OR of the patterns of all BLAST slots. o_bomb has bit cor set for each FUSE slot.
- game_active=0 blocks placement only; live fuses and blasts keep running to completion.

## Timing
- State updates and outputs are registered. o_bomb and o_explode reflect the slot state of the previous clk, so each output lags its state change by one clk.
- Placement: request at clk edge N → slot in FUSE after edge N → o_bomb bit set after edge N+1.
- Fuse expiry: the tick that takes ctr from 1 sets BLAST at edge N; o_explode is lit after edge N+1.
- Lifetime: a bomb fuses for exactly FUSE_TICKS tick strobes and blasts for exactly BLAST_TICKS tick strobes.
- Chain latency: 2 clk per link (one clk to see o_explode, one clk for the output register).
- Reset mid-operation clears everything on that edge; the first placement can be accepted on the following edge.

## Test plan
- Basic cycle:
  - stimulus: reset, FUSE_TICKS=3, BLAST_TICKS=2, P1 places at 0x55, tick every 4 clk;
  - required: o_bomb[0x55]=1 for 3 ticks; o_explode bits 0x55, 0x35, 0x45, 0x65, 0x75, 0x53, 0x54, 0x56 and 0x57 are 1 for 2 ticks; then all outputs are 0.
- Edge and wall clipping:
  - stimulus: bomb at 0x00 with i_wall[0x02]=1;
  - required: lit cells are exactly 0x00, 0x01, 0x10 and 0x20; no bit in row 15 and no bit at column 15 is set.
- Slot limit and duplicate cell:
  - stimulus: P1 requests at 0x11, 0x12 and 0x13 on successive clk, then P2 requests at 0x11;
  - required: 0x13 is rejected; P2's request at 0x11 is rejected; o_bomb has exactly bits 0x11 and 0x12 set.
- Simultaneous placement:
  - stimulus: P1 and P2 both request 0x44 in the same clk;
  - required: only slot 0 goes active; P2 still has 2 free slots afterwards.
- Chain reaction:
  - stimulus: bomb A at 0x22, bomb B at 0x23 placed 2 ticks later;
  - required: B enters BLAST 1 clk after o_explode[0x23] rises, not at B's own fuse expiry.
- Reset and game_active:
  - stimulus: drive reset=0 while a blast is lit, then release it; separately hold game_active=0 while placing;
  - required: outputs are 0 on the reset edge, and no bomb is placed while game_active=0.
